// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the ALU.
// It accepts one M-extension instruction at a time and stalls the core
// while 32 shift-add (multiply) or restoring-divide iterations run.
// It then applies the sign fix-up and strobes the registered result.
// Divide-by-zero and signed overflow are answered directly from IDLE.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid
);

    localparam int              CW        = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negation of a single word.
    function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v);
        return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negation of a double word (full product).
    function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v);
        return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r, state_next_s;
    logic [CW-1:0]       cnt_r;
    // Multiply: {carry, high, low/multiplier}. Divide: {remainder, quotient}.
    logic [2*XLEN:0]     acc_r;
    logic [XLEN-1:0]     mag_a_r, mag_b_r;
    logic                neg_main_r, neg_a_r;
    logic [2:0]          op_r;
    logic [XLEN-1:0]     result_r;
    logic                result_valid_r;

    logic                is_m_s, accept_s;
    logic                a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]     mag_a_s, mag_b_s;
    logic                div_zero_s, div_ovf_s, special_s;
    logic [XLEN-1:0]     special_result_s;
    logic [XLEN:0]       mul_sum_s;
    logic [2*XLEN:0]     mul_step_s;
    logic [XLEN:0]       rem_shift_s, rem_new_s;
    logic [XLEN+1:0]     diff_s;
    logic                borrow_s;
    logic [2*XLEN:0]     div_step_s;
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, rem_s, fix_result_s;

    // Decode and operand conditioning. Only MULHU/DIVU/REMU treat rs1 as unsigned.
    // MULHSU additionally treats rs2 as unsigned.
    assign is_m_s     = valid & (opcode == 7'b0110011) & (funct7 == 7'b0000001);
    assign accept_s   = (state_r == IDLE) & is_m_s & ~flush;
    assign a_signed_s = (funct3 != 3'b011) & (funct3 != 3'b101) & (funct3 != 3'b111);
    assign b_signed_s = a_signed_s & (funct3 != 3'b010);
    assign a_neg_s    = a_signed_s & rs1_data[XLEN-1];
    assign b_neg_s    = b_signed_s & rs2_data[XLEN-1];
    assign mag_a_s    = a_neg_s ? neg_word(rs1_data) : rs1_data;
    assign mag_b_s    = b_neg_s ? neg_word(rs2_data) : rs2_data;
    assign div_zero_s = funct3[2] & (rs2_data == {XLEN{1'b0}});
    assign div_ovf_s  = funct3[2] & ~funct3[0] & (rs1_data == MIN_INT) & (rs2_data == ALL_ONES);
    assign special_s  = div_zero_s | div_ovf_s;

    // Immediate answers for divide-by-zero and the signed overflow case.
    always_comb begin
        special_result_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_result_s = funct3[1] ? rs1_data : ALL_ONES;
        end else begin
            special_result_s = funct3[1] ? {XLEN{1'b0}} : MIN_INT;
        end
    end

    // One shift-add multiply step: add multiplicand on LSB, then shift right.
    assign mul_sum_s  = acc_r[2*XLEN:XLEN] + {1'b0, (acc_r[0] ? mag_a_r : {XLEN{1'b0}})};
    assign mul_step_s = {1'b0, mul_sum_s, acc_r[XLEN-1:1]};

    // One restoring-divide step: shift in the next dividend bit and trial-subtract.
    assign rem_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign diff_s      = {1'b0, rem_shift_s} - {2'b00, mag_b_r};
    assign borrow_s    = diff_s[XLEN+1];
    assign rem_new_s   = borrow_s ? rem_shift_s : diff_s[XLEN:0];
    assign div_step_s  = {rem_new_s, acc_r[XLEN-2:0], ~borrow_s};

    // Sign correction and word selection applied in FIX.
    assign prod_s = neg_main_r ? neg_dword(acc_r[2*XLEN-1:0]) : acc_r[2*XLEN-1:0];
    assign quot_s = neg_main_r ? neg_word(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
    assign rem_s  = neg_a_r ? neg_word(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];

    // Pick the architectural result for the latched funct3.
    always_comb begin
        fix_result_s = {XLEN{1'b0}};
        if (op_r[2]) begin
            fix_result_s = op_r[1] ? rem_s : quot_s;
        end else if (op_r[1:0] == 2'b00) begin
            fix_result_s = prod_s[XLEN-1:0];
        end else begin
            fix_result_s = prod_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_next_s = state_r;
        if (flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (is_m_s) begin
                        state_next_s = special_s ? DONE : CALC;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == LAST_ITER) begin
                        state_next_s = FIX;
                    end else begin
                        state_next_s = CALC;
                    end
                end
                FIX:     state_next_s = DONE;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register and result strobe; the strobe marks the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            result_valid_r <= (state_next_s == DONE);
        end
    end

    // Operand latch at accept, and iteration datapath with its counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {(2*XLEN+1){1'b0}};
            mag_a_r    <= {XLEN{1'b0}};
            mag_b_r    <= {XLEN{1'b0}};
            neg_main_r <= 1'b0;
            neg_a_r    <= 1'b0;
            op_r       <= 3'd0;
        end else if (flush) begin
            cnt_r <= {CW{1'b0}};
        end else if (accept_s) begin
            cnt_r      <= {CW{1'b0}};
            acc_r      <= {{(XLEN+1){1'b0}}, (funct3[2] ? mag_a_s : mag_b_s)};
            mag_a_r    <= mag_a_s;
            mag_b_r    <= mag_b_s;
            neg_main_r <= a_neg_s ^ b_neg_s;
            neg_a_r    <= a_neg_s;
            op_r       <= funct3;
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            acc_r <= op_r[2] ? div_step_s : mul_step_s;
        end
    end

    // Result register: loaded by a special-case accept or by FIX, otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {XLEN{1'b0}};
        end else if (accept_s && special_s) begin
            result_r <= special_result_s;
        end else if ((state_r == FIX) && !flush) begin
            result_r <= fix_result_s;
        end
    end

    assign stall        = is_m_s & ~result_valid_r;
    assign busy         = (state_r != IDLE);
    assign result       = result_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer.
module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .stall(stall), .busy(busy), .result(result), .result_valid(result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one M instruction from the next falling edge until the result strobe.
    // lat counts cycles from the accept cycle to the strobe cycle.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stalls,
                          output bit timeout);
        lat = 0; stalls = 0; timeout = 1'b1; res = 32'd0;
        @(negedge clk);
        valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
        funct3 = f3; rs1_data = a; rs2_data = b;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (result_valid === 1'b1) begin
                res = result; lat = i; timeout = 1'b0;
                if (stall !== 1'b0) stalls = stalls + 1000;
                break;
            end
            if (stall === 1'b1) stalls = stalls + 1;
            @(negedge clk);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        valid = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; flush = 1'b0; opcode = 7'd0; funct3 = 3'd0;
        funct7 = 7'd0; rs1_data = 32'd0; rs2_data = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, result_valid, stall, result} !== {3'b000, 32'd0}) begin
            errors++;
            $display("FAIL reset: busy=%b rv=%b stall=%b result=%h, need 0 0 0 00000000",
                     busy, result_valid, stall, result);
        end
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat, st; bit to;
        run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, st, to);
        checks++;
        if (to || r !== 32'hFFFFFFEB) begin
            errors++; $display("FAIL mul_value: got %h timeout=%0d, need FFFFFFEB", r, to);
        end
        checks++;
        if (lat !== 34) begin
            errors++; $display("FAIL mul_latency: got %0d, need 34", lat);
        end
        checks++;
        if (st !== 34) begin
            errors++; $display("FAIL mul_stall_cycles: got %0d, need 34", st);
        end
        idle_cycle();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || result !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mul_strobe_width: rv=%b busy=%b result=%h, need 0 0 FFFFFFEB",
                     result_valid, busy, result);
        end
    endtask

    task automatic test_mulh_back_to_back();
        logic [31:0] r; int lat, st; bit to;
        run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, st, to);
        checks++;
        if (to || r !== 32'h40000000) begin
            errors++; $display("FAIL mulh: got %h, need 40000000", r);
        end
        run_op(3'b011, 32'h80000000, 32'h80000000, r, lat, st, to);
        checks++;
        if (to || r !== 32'h40000000 || lat !== 34) begin
            errors++; $display("FAIL mulhu_b2b: got %h lat %0d, need 40000000 lat 34", r, lat);
        end
        run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, st, to);
        checks++;
        if (to || r !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL mulhsu: got %h, need FFFFFFFF", r);
        end
        idle_cycle();
    endtask

    task automatic test_divide();
        logic [31:0] r; int lat, st; bit to;
        logic [2:0]  f3 [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
        logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] b  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ex [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(f3[i], a[i], b[i], r, lat, st, to);
            checks++;
            if (to || r !== ex[i] || lat !== 34) begin
                errors++;
                $display("FAIL divide[%0d] f3=%b: got %h lat %0d, need %h lat 34",
                         i, f3[i], r, lat, ex[i]);
            end
            idle_cycle();
        end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat, st; bit to;
        logic [2:0]  f3 [5] = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
        logic [31:0] a  [5] = '{32'h1234, 32'h1234, 32'h80000000, 32'h80000000, 32'h55};
        logic [31:0] b  [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'h1234, 32'h80000000, 32'd0, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            run_op(f3[i], a[i], b[i], r, lat, st, to);
            checks++;
            if (to || r !== ex[i] || lat !== 1) begin
                errors++;
                $display("FAIL special[%0d] f3=%b: got %h lat %0d, need %h lat 1",
                         i, f3[i], r, lat, ex[i]);
            end
            idle_cycle();
        end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat, st; bit to; int seen;
        logic [31:0] prev;
        prev = result;
        @(negedge clk);
        valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
        funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
        repeat (10) @(negedge clk);
        flush = 1'b1; valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL flush_abort: busy=%b rv=%b result=%h, need 0 0 %h",
                     busy, result_valid, result, prev);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (result_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL flush_quiet: %0d active cycles, need 0", seen);
        end
        // flush together with an M op in IDLE: nothing accepted
        @(negedge clk);
        valid = 1'b1; funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            errors++; $display("FAIL flush_vs_accept: busy=%b rv=%b, need 0 0", busy, result_valid);
        end
        run_op(3'b000, 32'd6, 32'd7, r, lat, st, to);
        checks++;
        if (to || r !== 32'd42 || lat !== 34) begin
            errors++; $display("FAIL after_flush: got %h lat %0d, need 0000002a lat 34", r, lat);
        end
        idle_cycle();
    endtask

    task automatic test_rst_abort();
        logic [31:0] r; int lat, st; bit to; int seen;
        @(negedge clk);
        valid = 1'b1; opcode = 7'b0110011; funct7 = 7'b0000001;
        funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9;
        repeat (10) @(negedge clk);
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL rst_abort: busy=%b rv=%b result=%h, need 0 0 00000000",
                     busy, result_valid, result);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (result_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL rst_quiet: %0d strobes, need 0", seen);
        end
        run_op(3'b101, 32'd100, 32'd7, r, lat, st, to);
        checks++;
        if (to || r !== 32'd14 || lat !== 34) begin
            errors++; $display("FAIL after_rst: got %h lat %0d, need 0000000e lat 34", r, lat);
        end
        idle_cycle();
    endtask

    task automatic test_passthrough();
        logic [6:0] opc [2] = '{7'b0110011, 7'b0010011};
        logic [6:0] f7  [2] = '{7'b0000000, 7'b0000001};
        int bad;
        for (int k = 0; k < 2; k++) begin
            bad = 0;
            @(negedge clk);
            valid = 1'b1; opcode = opc[k]; funct7 = f7[k]; funct3 = 3'b000;
            rs1_data = 32'd5; rs2_data = 32'd6;
            for (int i = 0; i < 6; i++) begin
                #1;
                if (stall !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) bad++;
                @(negedge clk);
            end
            valid = 1'b0;
            checks++;
            if (bad !== 0) begin
                errors++; $display("FAIL passthrough[%0d]: %0d active cycles, need 0", k, bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh_back_to_back();
        test_divide();
        test_special();
        test_flush();
        test_rst_abort();
        test_passthrough();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
